// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - cell/state codes and winning-line table for the board checker
package jogo_pkg;

  typedef enum logic [1:0] {
    VAZIO  = 2'b00,
    X      = 2'b01,
    O      = 2'b10,
    EMPATE = 2'b11
  } celula_t;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    GRAVA        = 4'd1,
    VARRE_MICRO  = 4'd2,
    AVALIA_MICRO = 4'd3,
    VARRE_MACRO  = 4'd4,
    AVALIA_FIM   = 4'd5,
    PRONTO       = 4'd6
  } estado_t;

  // Three 4-bit cell positions of line 0..7, packed {a, b, c}.
  function automatic logic [11:0] linha_trio(input logic [2:0] linha);
    logic [11:0] trio;
    case (linha)
      3'd0:    trio = {4'd0, 4'd1, 4'd2};
      3'd1:    trio = {4'd3, 4'd4, 4'd5};
      3'd2:    trio = {4'd6, 4'd7, 4'd8};
      3'd3:    trio = {4'd0, 4'd3, 4'd6};
      3'd4:    trio = {4'd1, 4'd4, 4'd7};
      3'd5:    trio = {4'd2, 4'd5, 4'd8};
      3'd6:    trio = {4'd0, 4'd4, 4'd8};
      default: trio = {4'd2, 4'd4, 4'd6};
    endcase
    return trio;
  endfunction

  // Flat cell address macro*9 + micro; only meaningful for indices 0..8.
  function automatic logic [6:0] endereco(input logic [3:0] m, input logic [3:0] c);
    return 7'(m) * 7'd9 + 7'(c);
  endfunction

endpackage

// File: rtl/compara_linha.sv
// rtl/compara_linha.sv - flags a line whose three cells all hold the given player
module compara_linha
  import jogo_pkg::*;
(
  input  logic [1:0] celula_a,
  input  logic [1:0] celula_b,
  input  logic [1:0] celula_c,
  input  logic       jogador,
  output logic       casa
);

  logic [1:0] alvo;

  assign alvo = jogador ? O : X;
  assign casa = (celula_a == alvo) && (celula_b == alvo) && (celula_c == alvo);

endmodule

// File: rtl/verificador_tabuleiro.sv
// rtl/verificador_tabuleiro.sv - ultimate tic-tac-toe board store with sequential win/draw scan
module verificador_tabuleiro
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  input  logic       registra,
  input  logic       jogador,
  input  logic [3:0] macro,
  input  logic [3:0] micro,
  output logic       ocupado,
  output logic       verificando,
  output logic       pronto_verif,
  output logic       jogada_invalida,
  output logic       fim_jogo,
  output logic [1:0] vencedor,
  output logic       escolhe_macro,
  output logic [3:0] proximo_macro,
  output logic [3:0] db_estado
);

  estado_t          estado_q, estado_d;
  logic [80:0][1:0] celulas_q, celulas_d;
  logic [8:0][1:0]  status_q, status_d;
  logic             jogador_q, jogador_d;
  logic [3:0]       macro_q, macro_d;
  logic [3:0]       micro_q, micro_d;
  logic [2:0]       linha_q, linha_d;
  logic             vence_micro_q, vence_micro_d;
  logic             vence_macro_q, vence_macro_d;
  logic             invalida_q, invalida_d;
  logic             fim_q, fim_d;
  logic [1:0]       vencedor_q, vencedor_d;
  logic             escolhe_q, escolhe_d;
  logic [3:0]       proximo_q, proximo_d;

  logic [11:0] trio;
  logic [1:0]  cel_a, cel_b, cel_c;
  logic        casa;
  logic [1:0]  cod_jogador;
  logic        micro_cheio, macro_cheio;

  assign cod_jogador = jogador_q ? O : X;
  assign trio        = linha_trio(linha_q);

  // One comparator serves both scans; the operand source follows the state.
  always_comb begin
    if (estado_q == VARRE_MACRO) begin
      cel_a = status_q[trio[11:8]];
      cel_b = status_q[trio[7:4]];
      cel_c = status_q[trio[3:0]];
    end else begin
      cel_a = celulas_q[endereco(macro_q, trio[11:8])];
      cel_b = celulas_q[endereco(macro_q, trio[7:4])];
      cel_c = celulas_q[endereco(macro_q, trio[3:0])];
    end
  end

  compara_linha u_compara_linha (
    .celula_a (cel_a),
    .celula_b (cel_b),
    .celula_c (cel_c),
    .jogador  (jogador_q),
    .casa     (casa)
  );

  always_comb begin
    micro_cheio = 1'b1;
    macro_cheio = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (celulas_q[endereco(macro_q, 4'(i))] == VAZIO) micro_cheio = 1'b0;
      if (status_q[i] == VAZIO) macro_cheio = 1'b0;
    end
  end

  // Out-of-range indices count as occupied so they can never be written.
  always_comb begin
    ocupado = 1'b1;
    if ((macro <= 4'd8) && (micro <= 4'd8))
      ocupado = (celulas_q[endereco(macro, micro)] != VAZIO) || (status_q[macro] != VAZIO);
  end

  always_comb begin
    estado_d      = estado_q;
    celulas_d     = celulas_q;
    status_d      = status_q;
    jogador_d     = jogador_q;
    macro_d       = macro_q;
    micro_d       = micro_q;
    linha_d       = linha_q;
    vence_micro_d = vence_micro_q;
    vence_macro_d = vence_macro_q;
    invalida_d    = 1'b0;
    fim_d         = fim_q;
    vencedor_d    = vencedor_q;
    escolhe_d     = escolhe_q;
    proximo_d     = proximo_q;

    case (estado_q)
      OCIOSO: begin
        if (registra) begin
          if (ocupado) begin
            invalida_d = 1'b1;
          end else begin
            jogador_d = jogador;
            macro_d   = macro;
            micro_d   = micro;
            estado_d  = GRAVA;
          end
        end
      end
      GRAVA: begin
        celulas_d[endereco(macro_q, micro_q)] = cod_jogador;
        linha_d       = 3'd0;
        vence_micro_d = 1'b0;
        vence_macro_d = 1'b0;
        estado_d      = VARRE_MICRO;
      end
      VARRE_MICRO: begin
        if (casa) vence_micro_d = 1'b1;
        linha_d = linha_q + 3'd1;
        if (linha_q == 3'd7) estado_d = AVALIA_MICRO;
      end
      AVALIA_MICRO: begin
        linha_d = 3'd0;
        if (vence_micro_q) begin
          status_d[macro_q] = cod_jogador;
          estado_d          = VARRE_MACRO;
        end else if (micro_cheio) begin
          status_d[macro_q] = EMPATE;
          estado_d          = VARRE_MACRO;
        end else begin
          estado_d = AVALIA_FIM;
        end
      end
      VARRE_MACRO: begin
        if (casa) vence_macro_d = 1'b1;
        linha_d = linha_q + 3'd1;
        if (linha_q == 3'd7) estado_d = AVALIA_FIM;
      end
      AVALIA_FIM: begin
        if (vence_macro_q) begin
          fim_d      = 1'b1;
          vencedor_d = cod_jogador;
        end else if (macro_cheio) begin
          fim_d      = 1'b1;
          vencedor_d = EMPATE;
        end else begin
          fim_d      = 1'b0;
          vencedor_d = VAZIO;
        end
        proximo_d = micro_q;
        escolhe_d = (status_q[micro_q] != VAZIO);
        estado_d  = PRONTO;
      end
      PRONTO:  estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    // Clear overrides everything, including a move strobed in the same cycle.
    if (limpa) begin
      estado_d      = OCIOSO;
      celulas_d     = '0;
      status_d      = '0;
      jogador_d     = 1'b0;
      macro_d       = 4'd0;
      micro_d       = 4'd0;
      linha_d       = 3'd0;
      vence_micro_d = 1'b0;
      vence_macro_d = 1'b0;
      invalida_d    = 1'b0;
      fim_d         = 1'b0;
      vencedor_d    = 2'b00;
      escolhe_d     = 1'b0;
      proximo_d     = 4'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      celulas_q     <= '0;
      status_q      <= '0;
      jogador_q     <= 1'b0;
      macro_q       <= 4'd0;
      micro_q       <= 4'd0;
      linha_q       <= 3'd0;
      vence_micro_q <= 1'b0;
      vence_macro_q <= 1'b0;
      invalida_q    <= 1'b0;
      fim_q         <= 1'b0;
      vencedor_q    <= 2'b00;
      escolhe_q     <= 1'b0;
      proximo_q     <= 4'd0;
    end else begin
      estado_q      <= estado_d;
      celulas_q     <= celulas_d;
      status_q      <= status_d;
      jogador_q     <= jogador_d;
      macro_q       <= macro_d;
      micro_q       <= micro_d;
      linha_q       <= linha_d;
      vence_micro_q <= vence_micro_d;
      vence_macro_q <= vence_macro_d;
      invalida_q    <= invalida_d;
      fim_q         <= fim_d;
      vencedor_q    <= vencedor_d;
      escolhe_q     <= escolhe_d;
      proximo_q     <= proximo_d;
    end
  end

  assign verificando     = (estado_q != OCIOSO);
  assign pronto_verif    = (estado_q == PRONTO);
  assign jogada_invalida = invalida_q;
  assign fim_jogo        = fim_q;
  assign vencedor        = vencedor_q;
  assign escolhe_macro   = escolhe_q;
  assign proximo_macro   = proximo_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_verificador_tabuleiro.sv
// tb/tb_verificador_tabuleiro.sv - randomized self-checking bench against a board-level reference model
module tb_verificador_tabuleiro;

  logic       clock = 1'b0;
  logic       reset, limpa, registra, jogador;
  logic [3:0] macro, micro;
  logic       ocupado, verificando, pronto_verif, jogada_invalida, fim_jogo, escolhe_macro;
  logic [1:0] vencedor;
  logic [3:0] proximo_macro, db_estado;

  int checks = 0;
  int errors = 0;

  int tab[9][9];
  int st[9];
  int m_fim, m_venc, m_esc, m_prox;
  int linhas[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int padrao[9] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};

  verificador_tabuleiro dut (
    .clock           (clock),
    .reset           (reset),
    .limpa           (limpa),
    .registra        (registra),
    .jogador         (jogador),
    .macro           (macro),
    .micro           (micro),
    .ocupado         (ocupado),
    .verificando     (verificando),
    .pronto_verif    (pronto_verif),
    .jogada_invalida (jogada_invalida),
    .fim_jogo        (fim_jogo),
    .vencedor        (vencedor),
    .escolhe_macro   (escolhe_macro),
    .proximo_macro   (proximo_macro),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  function automatic void zera_modelo();
    for (int i = 0; i < 9; i++) begin
      st[i] = 0;
      for (int j = 0; j < 9; j++) tab[i][j] = 0;
    end
    m_fim = 0; m_venc = 0; m_esc = 0; m_prox = 0;
  endfunction

  function automatic bit ganha_micro(input int m, input int cod);
    for (int l = 0; l < 8; l++)
      if (tab[m][linhas[l][0]] == cod && tab[m][linhas[l][1]] == cod && tab[m][linhas[l][2]] == cod)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ganha_macro(input int cod);
    for (int l = 0; l < 8; l++)
      if (st[linhas[l][0]] == cod && st[linhas[l][1]] == cod && st[linhas[l][2]] == cod)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit cheio_micro(input int m);
    for (int j = 0; j < 9; j++) if (tab[m][j] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit cheio_macro();
    for (int j = 0; j < 9; j++) if (st[j] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic confere_resultados(input string tag);
    verifica({tag, "_fim"}, fim_jogo, m_fim);
    verifica({tag, "_vencedor"}, vencedor, m_venc);
    verifica({tag, "_escolhe"}, escolhe_macro, m_esc);
    verifica({tag, "_proximo"}, proximo_macro, m_prox);
  endtask

  task automatic limpa_tab();
    limpa = 1'b1;
    @(posedge clock); #1;
    limpa = 1'b0;
    zera_modelo();
    confere_resultados("limpa");
    verifica("limpa_verificando", verificando, 0);
  endtask

  // Plays one move: checks ocupado, then the invalid pulse or the full evaluation.
  task automatic jogar(input int m, input int c, input int p);
    int  cod, lat, cyc;
    bit  exp_ocup, decidido, vm;
    macro   = m[3:0];
    micro   = c[3:0];
    jogador = p[0];
    #1;
    exp_ocup = (m > 8) || (c > 8);
    if (!exp_ocup) exp_ocup = (tab[m][c] != 0) || (st[m] != 0);
    verifica("ocupado", ocupado, exp_ocup);
    registra = 1'b1;
    @(posedge clock); #1;
    registra = 1'b0;
    if (exp_ocup) begin
      verifica("invalida_c1", jogada_invalida, 1);
      verifica("invalida_verificando", verificando, 0);
      @(posedge clock); #1;
      verifica("invalida_c2", jogada_invalida, 0);
      confere_resultados("invalida");
      return;
    end
    cod = p ? 2 : 1;
    tab[m][c] = cod;
    decidido = 1'b0;
    if (ganha_micro(m, cod)) begin
      st[m] = cod; decidido = 1'b1;
    end else if (cheio_micro(m)) begin
      st[m] = 3; decidido = 1'b1;
    end
    vm = decidido && ganha_macro(cod);
    if (vm) begin
      m_fim = 1; m_venc = cod;
    end else if (cheio_macro()) begin
      m_fim = 1; m_venc = 3;
    end else begin
      m_fim = 0; m_venc = 0;
    end
    m_prox = c;
    m_esc  = (st[c] != 0);
    lat = decidido ? 20 : 12;
    verifica("estado_c1", db_estado, 1);
    verifica("verificando_c1", verificando, 1);
    verifica("invalida_aceita", jogada_invalida, 0);
    cyc = 1;
    while (!pronto_verif && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    verifica("latencia_pronto", cyc, lat);
    confere_resultados("jogada");
    @(posedge clock); #1;
    verifica("pronto_pulso", pronto_verif, 0);
    verifica("ocioso_apos", verificando, 0);
  endtask

  initial begin
    reset = 1'b1; limpa = 1'b0; registra = 1'b0; jogador = 1'b0;
    macro = 4'd0; micro = 4'd0;
    zera_modelo();
    repeat (2) @(posedge clock);
    #1;
    verifica("rst_estado", db_estado, 0);
    verifica("rst_verificando", verificando, 0);
    verifica("rst_pronto", pronto_verif, 0);
    verifica("rst_invalida", jogada_invalida, 0);
    confere_resultados("rst");
    reset = 1'b0;
    @(posedge clock); #1;

    // reset in the middle of a micro scan
    macro = 4'd0; micro = 4'd0; jogador = 1'b0; registra = 1'b1;
    @(posedge clock); #1;
    registra = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    verifica("midscan_verificando", verificando, 1);
    reset = 1'b1;
    #1;
    verifica("midscan_estado", db_estado, 0);
    verifica("midscan_pronto", pronto_verif, 0);
    confere_resultados("midscan");
    @(posedge clock); #1;
    reset = 1'b0;
    verifica("midscan_celula_vazia", ocupado, 0);

    // clear and strobe together: the move is dropped
    macro = 4'd1; micro = 4'd1; limpa = 1'b1; registra = 1'b1;
    @(posedge clock); #1;
    limpa = 1'b0; registra = 1'b0;
    verifica("limpa_registra_verif", verificando, 0);
    verifica("limpa_registra_inval", jogada_invalida, 0);
    verifica("limpa_registra_ocup", ocupado, 0);

    // micro win without game end
    jogar(4, 0, 0); jogar(4, 1, 0); jogar(5, 0, 1); jogar(4, 2, 0);
    verifica("microwin_fim", fim_jogo, 0);
    verifica("microwin_proximo", proximo_macro, 2);
    verifica("microwin_escolhe", escolhe_macro, 0);

    // occupied cell
    jogar(3, 5, 0); jogar(3, 5, 1);

    // drawn micro board gives free choice
    limpa_tab();
    for (int i = 0; i < 9; i++) jogar(2, i, padrao[i]);
    jogar(0, 2, 0);
    verifica("livre_escolhe", escolhe_macro, 1);
    verifica("livre_proximo", proximo_macro, 2);

    // O wins macro boards 2, 4, 6
    limpa_tab();
    foreach (padrao[k]) if (k == 2 || k == 4 || k == 6)
      for (int i = 0; i < 3; i++) jogar(k, i, 1);
    verifica("vitoria_fim", fim_jogo, 1);
    verifica("vitoria_vencedor", vencedor, 2);

    // macro draw, then clear
    limpa_tab();
    for (int k = 0; k < 9; k++)
      for (int i = 0; i < 3; i++) jogar(k, i, padrao[k]);
    verifica("empate_fim", fim_jogo, 1);
    verifica("empate_vencedor", vencedor, 3);
    limpa_tab();
    macro = 4'd0; micro = 4'd0;
    #1;
    verifica("empate_limpo_ocupado", ocupado, 0);

    // random play, including out-of-range and repeated cells
    for (int g = 0; g < 4; g++) begin
      limpa_tab();
      repeat (70) jogar($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
